// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FP32 add/sub operation sequencer.
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP32_INF_MAG = 32'h7F80_0000;

    typedef struct packed {
        logic invalid;
        logic special;
        logic timeout;
    } rsp_flags_t;

endpackage

// File: rtl/fpu_special_resolve.sv
// Purpose: classify two FP32 operands and resolve IEEE add/sub special cases.
// Latency: purely combinational.
// Backpressure: none; the caller samples the outputs when it needs them.
module fpu_special_resolve
    import fpu_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        is_special,
    output logic [31:0] result,
    output logic        invalid
);

    logic        sa;
    logic        sb_eff;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa     = a[31];
    assign sb_eff = b[31] ^ (op == OP_SUB);
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];

    // Subnormals (exp 0, frac != 0) match none of these and go to the core.
    assign a_nan  = (ea == 8'hFF) && (fa != '0);
    assign b_nan  = (eb == 8'hFF) && (fb != '0);
    assign a_inf  = (ea == 8'hFF) && (fa == '0);
    assign b_inf  = (eb == 8'hFF) && (fb == '0);
    assign a_zero = (ea == 8'h00) && (fa == '0);
    assign b_zero = (eb == 8'h00) && (fb == '0);

    always_comb begin
        is_special = 1'b1;
        invalid    = 1'b0;
        result     = a;
        if (a_nan || b_nan) begin
            result = FP32_QNAN;
        end else if (a_inf && b_inf) begin
            if (sa != sb_eff) begin
                result  = FP32_QNAN;
                invalid = 1'b1;
            end else begin
                result = FP32_INF_MAG | {sa, 31'b0};
            end
        end else if (a_inf) begin
            result = FP32_INF_MAG | {sa, 31'b0};
        end else if (b_inf) begin
            result = FP32_INF_MAG | {sb_eff, 31'b0};
        end else if (a_zero && b_zero) begin
            result = {sa & sb_eff, 31'b0};
        end else if (a_zero) begin
            result = {sb_eff, b[30:0]};
        end else if (b_zero) begin
            result = a;
        end else begin
            is_special = 1'b0;
            result     = '0;
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Purpose: single-issue FSM fronting the FP32 add/sub core; special cases resolved locally.
// Latency: special path 2 cycles to rsp_valid; core path 4+k, or abort after TIMEOUT WAIT cycles.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             core_start,
    output logic             core_op,
    output logic [31:0]      core_a,
    output logic [31:0]      core_b,
    input  logic             core_done,
    input  logic [31:0]      core_result,
    output logic             core_abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_invalid,
    output logic             rsp_special,
    output logic             rsp_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             op_q;
    logic [TAG_W-1:0] tag_q;
    logic [TW-1:0]    timer;
    rsp_flags_t       flags;

    logic             sp_hit;
    logic [31:0]      sp_result;
    logic             sp_invalid;

    fpu_special_resolve u_special (
        .a          (a_q),
        .b          (b_q),
        .op         (op_q),
        .is_special (sp_hit),
        .result     (sp_result),
        .invalid    (sp_invalid)
    );

    assign req_ready   = (state == S_IDLE) && !rst;
    assign core_a      = a_q;
    assign core_b      = b_q;
    assign core_op     = op_q;
    assign rsp_invalid = flags.invalid;
    assign rsp_special = flags.special;
    assign rsp_timeout = flags.timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            tag_q      <= '0;
            timer      <= '0;
            core_start <= 1'b0;
            core_abort <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            flags      <= '0;
        end else begin
            core_start <= 1'b0;
            core_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q   <= req_a;
                        b_q   <= req_b;
                        op_q  <= req_op;
                        tag_q <= req_tag;
                        state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (sp_hit) begin
                        rsp_result <= sp_result;
                        rsp_tag    <= tag_q;
                        flags      <= '{invalid: sp_invalid, special: 1'b1, timeout: 1'b0};
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        core_start <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= TW'(TIMEOUT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving with the last timer tick still counts as success.
                    if (core_done) begin
                        rsp_result <= core_result;
                        rsp_tag    <= tag_q;
                        flags      <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (timer == TW'(1)) begin
                        core_abort <= 1'b1;
                        timer      <= '0;
                        rsp_result <= FP32_QNAN;
                        rsp_tag    <= tag_q;
                        flags      <= '{invalid: 1'b0, special: 1'b0, timeout: 1'b1};
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Table-driven bench with an expected-response queue for fpu_op_sequencer.
module tb_fpu_op_sequencer;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             core_start;
    logic             core_op;
    logic [31:0]      core_a;
    logic [31:0]      core_b;
    logic             core_done;
    logic [31:0]      core_result;
    logic             core_abort;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_invalid;
    logic             rsp_special;
    logic             rsp_timeout;

    fpu_op_sequencer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .core_start  (core_start),
        .core_op     (core_op),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_done   (core_done),
        .core_result (core_result),
        .core_abort  (core_abort),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_invalid (rsp_invalid),
        .rsp_special (rsp_special),
        .rsp_timeout (rsp_timeout)
    );

    always #5 clk = ~clk;

    // dly: cycles from core_start to core_done (-1 = never); hold: cycles rsp_ready stays low
    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        int          dly;
        logic [31:0] core_res;
        int          hold;
        logic [31:0] exp_res;
        logic        inv;
        logic        spec;
        logic        to;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        inv;
        logic        spec;
        logic        to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   start_cyc = -1;
        int   starts = 0;
        int   aborts = 0;
        int   rsp_cyc = -1;
        int   held = 0;
        bit   stable_ok = 1'b1;
        bit   hold_ok = 1'b1;
        bit   got = 1'b0;
        logic [39:0] snap = '0;
        int   exp_cyc;

        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d idle req_ready", idx), req_ready, 1);
        chk($sformatf("v%0d idle rsp_valid", idx), rsp_valid, 0);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
        e = '{res: v.exp_res, tag: v.tag, inv: v.inv, spec: v.spec, to: v.to};
        sb.push_back(e);
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            core_done = 1'b0;
            if (core_start) begin
                starts++;
                start_cyc = cyc;
            end
            if (core_abort) aborts++;
            if (start_cyc >= 0 && rsp_cyc < 0 &&
                (core_a !== v.a || core_b !== v.b || core_op !== v.op)) stable_ok = 1'b0;
            if (v.dly >= 0 && start_cyc >= 0 && cyc == start_cyc + v.dly) begin
                core_done   = 1'b1;
                core_result = v.core_res;
            end
            if (rsp_valid) begin
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc;
                    snap = {rsp_result, rsp_tag, rsp_invalid, rsp_special, rsp_timeout, 1'b0};
                end
                if (snap !== {rsp_result, rsp_tag, rsp_invalid, rsp_special, rsp_timeout, 1'b0}
                    || req_ready !== 1'b0) hold_ok = 1'b0;
                if (held >= v.hold) begin
                    rsp_ready = 1'b1;
                    if (sb.size() == 0) begin
                        chk($sformatf("v%0d queue nonempty", idx), 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("v%0d result", idx), rsp_result, e.res);
                        chk($sformatf("v%0d tag", idx), rsp_tag, e.tag);
                        chk($sformatf("v%0d flags", idx),
                            {rsp_invalid, rsp_special, rsp_timeout}, {e.inv, e.spec, e.to});
                    end
                    @(posedge clk);
                    got = 1'b1;
                end
                held++;
            end
        end
        core_done = 1'b0;
        if (!got) begin
            chk($sformatf("v%0d response within budget", idx), 0, 1);
            void'(sb.pop_front());
        end
        exp_cyc = v.spec ? 2 : (v.dly >= 0 ? 2 + v.dly + 1 : 2 + TIMEOUT + 1);
        chk($sformatf("v%0d rsp latency", idx), rsp_cyc, exp_cyc);
        chk($sformatf("v%0d core_start count", idx), starts, v.spec ? 0 : 1);
        if (!v.spec) chk($sformatf("v%0d core_start cycle", idx), start_cyc, 2);
        chk($sformatf("v%0d core_abort count", idx), aborts, v.to ? 1 : 0);
        chk($sformatf("v%0d core operands stable", idx), stable_ok, 1);
        chk($sformatf("v%0d rsp hold stable", idx), hold_ok, 1);
    endtask

    initial begin
        bit quiet;
        vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 4'h3,  3, 32'h40400000, 0, 32'h40400000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h7F800000, 32'h7F800000, 4'h5, -1, 32'h0,        0, 32'h7FC00000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h7F800000, 32'h7F800000, 4'h6, -1, 32'h0,        0, 32'h7F800000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h80000000, 32'h80000000, 4'h7, -1, 32'h0,        0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h80000000, 32'h80000000, 4'h8, -1, 32'h0,        0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h00000000, 32'hC0000000, 4'h9, -1, 32'h0,        0, 32'hC0000000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 4'hA, -1, 32'h0,        0, 32'h7FC00000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'h00000001, 32'h3F800000, 4'hB,  1, 32'h3F800000, 0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h3F800000, 32'hFF800000, 4'hC, -1, 32'h0,        0, 32'h7F800000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h00000000, 32'h3F800000, 4'hD, -1, 32'h0,        0, 32'hBF800000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h40400000, 32'h00000000, 4'hE, -1, 32'h0,        5, 32'h40400000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h40000000, 32'h40000000, 4'h2,  8, 32'h40800000, 0, 32'h40800000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
        core_done = 1'b0; core_result = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs zero",
            {core_start, core_abort, rsp_valid, rsp_result, rsp_tag, rsp_invalid,
             rsp_special, rsp_timeout, core_a, core_b, core_op}, '0);
        chk("reset req_ready", req_ready, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Timeout, then a late core_done two cycles after the abort must be ignored.
        run_vec('{1'b0, 32'h3F800000, 32'h3F800000, 4'h4, -1, 32'h0, 0, 32'h7FC00000, 1'b0, 1'b0, 1'b1}, 12);
        @(negedge clk);
        core_done = 1'b1; core_result = 32'hDEADBEEF;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_done = 1'b0;
            if (rsp_valid || core_start || core_abort || !req_ready) quiet = 1'b0;
        end
        chk("late done ignored", quiet, 1);
        run_vec(vecs[0], 13);

        // Reset pulsed mid-WAIT: everything clears, no abort, following done ignored.
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_a = 32'h3F800000; req_b = 32'h3F800000; req_tag = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wait reset outputs zero",
            {core_start, core_abort, rsp_valid, rsp_result, rsp_tag, rsp_invalid,
             rsp_special, rsp_timeout, core_a, core_b, core_op}, '0);
        chk("wait reset req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post reset idle", req_ready, 1);
        core_done = 1'b1; core_result = 32'h12345678;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_done = 1'b0;
            if (rsp_valid || core_abort || core_start || rsp_result != 0) quiet = 1'b0;
        end
        chk("post reset done ignored", quiet, 1);
        run_vec(vecs[2], 14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got no finish, expected finish");
        $fatal(1);
    end

endmodule
